gf_seq_mult: RTL
================

Name: gf_seq_mult

Overview:
- Iterative shift-and-add multiplier sitting directly upstream of the carry-option adder stage in the GF datapath.
- One shift-and-add step per clock: WIDTH cycles per operation, one 2*WIDTH-bit accumulate per cycle.
- Mode is selected by carry_option, with the same semantics as the adder:
  - carry_option=1: integer multiply (accumulate with a full add).
  - carry_option=0: carry-less GF(2)[x] polynomial multiply (accumulate with XOR).
- The unreduced 2*WIDTH-bit product is handed downstream through a valid/ready handshake.

Parameters:
- WIDTH, 32, operand width in bits. Product width is 2*WIDTH. Legal range 2..64.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  operand set is valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- carry_option  input  1  1 = integer multiply, 0 = carry-less multiply; sampled on accept.
- a  input  WIDTH  multiplicand; sampled on accept.
- b  input  WIDTH  multiplier; sampled on accept.
- out_valid  output  1  product is valid; high only in DONE.
- out_ready  input  1  downstream accepts the product.
- product  output  2*WIDTH  result; stable for as long as out_valid is high.

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, product=0, internal registers=0. Reset mid-operation aborts the operation; no output is produced for it.

States:
- IDLE
  - in_ready=1.
  - On in_valid=1 at a rising edge (accept): latch acc=0, a_sh=zero-extended a (2*WIDTH bits), b_sh=b, mode=carry_option, cnt=0; go to RUN.
- RUN
  - in_ready=0. One step per edge:
    - If b_sh[0]=1: acc = mode ? (acc + a_sh) mod 2^(2*WIDTH) : (acc ^ a_sh).
    - Then a_sh <<= 1, b_sh >>= 1, cnt += 1.
  - After the step with cnt=WIDTH-1: product=final acc, go to DONE.
- DONE
  - out_valid=1; product held constant.
  - On out_ready=1 at an edge: go to IDLE. out_valid falls and in_ready rises in the same cycle.
  - out_ready=0 holds DONE indefinitely with product unchanged.

Timing and rules:
- Latency: accept edge E; out_valid is high in the cycle after edge E+WIDTH.
- Throughput: at most one operation per WIDTH+2 cycles. There is no overlap, because in_ready=0 in RUN and in DONE.
- No early termination: a b with few set bits still takes WIDTH cycles.
- Changes on a, b, carry_option or in_valid while in RUN or DONE are ignored.
- out_ready while in IDLE or RUN is ignored.
- Integer mode never overflows 2*WIDTH bits, so there is no carry-out port.
- The mod 2^(2*WIDTH) wrap in the add is never exercised and needs no special handling.
- product keeps its last value in IDLE until the next completion, or reset.
- in_valid and out_ready are both allowed to be held high continuously. Back-to-back operations then complete every WIDTH+2 cycles.

Test Plan:
- Integer mode: reset, then accept a=3, b=3, carry_option=1 -> out_valid rises exactly 32 cycles after accept; product=9. Repeat with carry_option=0 -> product=5.
- Carry-less mode: a=7, b=7, carry_option=0 -> product=21 (0x15). Same operands with carry_option=1 -> product=49.
- Width extremes: a=b=0xFFFFFFFF, carry_option=1 -> product=0xFFFFFFFE00000001. With carry_option=0 -> product=0x5555555555555555. Also a=0 or b=0 in either mode -> product=0, still after 32 cycles.
- Backpressure and input masking:
  - Hold out_ready=0 for 10 cycles after completion -> out_valid stays 1, product stays constant, in_ready stays 0.
  - Change a, b and carry_option during RUN -> result is unaffected.
  - Raise out_ready -> next cycle out_valid=0, in_ready=1.
- Reset mid-operation: assert rst asynchronously (between edges) at cycle 15 of RUN -> out_valid=0, product=0, in_ready=1 immediately. A new operation accepted after reset release completes correctly: a=10, b=25, carry_option=1 -> product=250.
- Streaming: in_valid=1 and out_ready=1 held continuously with three operand sets (10×25 integer, 28×72 integer, 3×3 carry-less) -> products 250, 2016, 5 in order, completions exactly 34 cycles apart.

Source files
------------

// File: rtl/gf_seq_mult_if.sv
// Operand/product handshake bundle for the sequential GF / integer multiplier.
// The master side (upstream + downstream) drives operands and out_ready;
// the slave side (the multiplier) answers with in_ready, out_valid and product.
interface gf_seq_mult_if #(
  parameter int WIDTH = 32
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic                 carry_option;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output in_valid,
    output carry_option,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  product
  );

  modport slave (
    input  in_valid,
    input  carry_option,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output product
  );

endinterface

// File: rtl/gf_seq_mult.sv
// Iterative shift-and-add multiplier feeding the carry-option adder stage.
// carry_option=1 accumulates with a full add (integer product), 0 with XOR
// (carry-less GF(2)[x] product). One partial product per clock, WIDTH clocks
// per operation, unreduced 2*WIDTH-bit result handed out over valid/ready.
module gf_seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  gf_seq_mult_if.slave       bus
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  // Step counter value of the final shift-and-add step.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One accumulate: full add in integer mode, XOR in carry-less mode.
  // The integer sum never exceeds 2*WIDTH bits, so the natural wrap is unused.
  function automatic logic [PW-1:0] accumulate(
    input logic [PW-1:0] acc,
    input logic [PW-1:0] addend,
    input logic          mode
  );
    logic [PW-1:0] res;
    if (mode) begin
      res = acc + addend;
    end else begin
      res = acc ^ addend;
    end
    return res;
  endfunction

  state_e            state_q, state_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic              mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     product_q, product_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  // Accumulator value after the current step (only meaningful in RUN).
  logic [PW-1:0]     step_acc_s;

  // Conditionally add the shifted multiplicand selected by the multiplier LSB.
  always_comb begin
    step_acc_s = acc_q;
    if (b_sh_q[0]) begin
      step_acc_s = accumulate(acc_q, a_sh_q, mode_q);
    end else begin
      step_acc_s = acc_q;
    end
  end

  // Next-state and datapath control: accept in IDLE, step in RUN, hold in DONE.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          acc_d   = {PW{1'b0}};
          a_sh_d  = {{WIDTH{1'b0}}, bus.a};
          b_sh_d  = bus.b;
          mode_d  = bus.carry_option;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        // Operands on the bus are ignored here; only the latched copies matter.
        acc_d  = step_acc_s;
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          product_d = step_acc_s;
          state_d   = ST_DONE;
        end else begin
          state_d   = ST_RUN;
        end
      end

      ST_DONE: begin
        // Product is held; the downstream stage releases us.
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs are decoded from the next state so they leave flops.
  always_comb begin
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= {PW{1'b0}};
      a_sh_q      <= {PW{1'b0}};
      b_sh_q      <= {WIDTH{1'b0}};
      mode_q      <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      product_q   <= {PW{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;

endmodule
